sm83_alu_nibble_seq: RTL and testbench
======================================

Name: sm83_alu_nibble_seq

Overview:
- Upstream stage of the SM83 ALU flag register block.
- Executes one 8-bit ALU operation as two 4-bit passes (low nibble, then high nibble) over consecutive clocks, using a single 4-bit slice.
- Produces the result byte plus zero, carry, half-carry, subtract and DAA-carry strobes that the flag register latches on `done`.

Parameters:
- WORD_SIZE, 8, operand/result width; must be 8 (two nibbles); other values are unsupported.
- NIBBLE, 4, slice width; fixed.

Ports:
- clk  input  1  system clock, all state on rising edge
- reset_n  input  1  asynchronous active-low reset
- start  input  1  request; accepted only when busy=0
- op  input  4  alu_op_t: ADD, ADC, SUB, SBC, AND, XOR, OR, CP, DAA
- a  input  8  accumulator operand
- b  input  8  second operand (ignored for DAA)
- carry_flag  input  1  current carry flag (ADC/SBC carry-in, DAA)
- half_flag  input  1  current half-carry flag (DAA)
- neg_flag  input  1  current subtract flag (DAA)
- busy  output  1  operation in progress
- done  output  1  one-cycle pulse; outputs below valid while high
- result  output  8  result byte
- result_we  output  1  result should be written back (0 for CP)
- zero_out  output  1  result==0
- half_out  output  1  carry/borrow out of bit 3
- neg_out  output  1  1 for SUB/SBC/CP; neg_flag passthrough for DAA; else 0
- carry_out  output  1  carry/borrow out of bit 7
- daa_carry_out  output  1  DAA carry decision (feeds flag block daa_carry_in)

Behaviour:
- Reset (async, reset_n=0): state=IDLE; busy, done, result, result_we, zero_out, half_out, neg_out, carry_out, daa_carry_out all 0. Reset mid-operation aborts it; no done is issued.
- FSM states: IDLE -> LO -> HI -> IDLE.
  - IDLE: start=1 latches op, a, b and the flag inputs; next state LO. Operands latched at accept; later input changes have no effect.
  - LO: slice computes bits 3:0 with carry-in c0. Register the low nibble, the nibble carry, and a low-zero bit. Next state HI.
  - HI: slice computes bits 7:4 with the registered nibble carry. Register the full result and flags. Next state IDLE, with done=1 for exactly the following cycle.
- Latency: start sampled at edge N; done high between edges N+3 and N+4. busy high from edge N+1 until done; busy=0 in the done cycle.
- Back-to-back: start may be asserted in the done cycle and is accepted at that edge. start while busy is ignored, not queued.
- Outputs hold their last values until the next done. done is never high for two consecutive cycles.
- Carry-in c0:
  - ADC: carry_flag. SBC: carry_flag. Otherwise 0.
  - Subtraction is performed as a + ~b + !c0.
  - half_out and carry_out for SUB/SBC/CP report borrow, i.e. the inverted slice carry.
- Logic ops: AND gives H=1, C=0. OR and XOR give H=0, C=0. Z is computed from the result.
- CP: same as SUB, but result_we=0.
- DAA: the correction byte is computed in IDLE at accept.
  - neg_flag=0: add 0x06 if half_flag or a[3:0]>9. Add 0x60 and set daa carry if carry_flag or a>0x99.
  - neg_flag=1: subtract 0x06 if half_flag. Subtract 0x60 if carry_flag; daa carry=carry_flag.
  - The two nibble passes add (or subtract) the correction.
  - Output flags: half_out=0, carry_out=daa_carry_out, Z from result, neg_out=neg_flag.
- daa_carry_out=0 for every non-DAA op.
- Unknown op: treated as ADD with result_we=0.

Decomposition:
- Shared package sm83_alu_pkg holds: alu_op_t enum (4-bit encoding above), alu_state_t (IDLE/LO/HI), DAA constants 0x06/0x60/0x99/9.
- Sub-module sm83_alu_nibble: combinational 4-bit slice. Inputs: x, y, cin, mode (add/and/or/xor). Outputs: sum, cout, nib_zero. Instantiated once and time-multiplexed across LO and HI.

Test Plan:
- ADD a=0x3A, b=0xC6 -> result 0x00, Z=1, H=1, C=1, N=0, result_we=1; done exactly 3 cycles after the accept edge.
- SBC a=0x3B, b=0x4F, carry_flag=1 -> result 0xEB, Z=0, H=1, C=1, N=1.
- CP a=0x3E, b=0x3E -> result_we=0, Z=1, N=1, H=0, C=0. AND a=0xF0, b=0x0F -> 0x00, Z=1, H=1, C=0.
- DAA a=0x7D, neg_flag=0, half_flag=0, carry_flag=0 -> 0x83, C=0, daa_carry_out=0. DAA a=0x9A, flags 0 -> 0x00, Z=1, C=1, daa_carry_out=1.
- start held high for 6 cycles with changing operands -> exactly two operations complete, the second accepted in the first done cycle, each using operands sampled at its own accept edge.
- reset_n pulsed low during HI -> all outputs 0 immediately (async), no done pulse; the next start after release completes normally.

Source files
------------

// File: rtl/sm83_alu_pkg.sv
// Shared types and constants for the SM83 nibble-serial ALU.
package sm83_alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD = 4'd0,
    OP_ADC = 4'd1,
    OP_SUB = 4'd2,
    OP_SBC = 4'd3,
    OP_AND = 4'd4,
    OP_XOR = 4'd5,
    OP_OR  = 4'd6,
    OP_CP  = 4'd7,
    OP_DAA = 4'd8
  } alu_op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LO   = 2'd1,
    ST_HI   = 2'd2
  } alu_state_t;

  typedef enum logic [1:0] {
    NM_ADD = 2'd0,
    NM_AND = 2'd1,
    NM_OR  = 2'd2,
    NM_XOR = 2'd3
  } nib_mode_t;

  // How half/carry are formed once both passes are done.
  typedef enum logic [1:0] {
    FK_ARITH = 2'd0,
    FK_AND   = 2'd1,
    FK_LOGIC = 2'd2,
    FK_DAA   = 2'd3
  } flag_kind_t;

  localparam logic [7:0] DAA_LO_ADJ   = 8'h06;
  localparam logic [7:0] DAA_HI_ADJ   = 8'h60;
  localparam logic [7:0] DAA_HI_LIMIT = 8'h99;
  localparam logic [3:0] DAA_LO_LIMIT = 4'd9;

endpackage

// File: rtl/sm83_alu_nibble.sv
// Combinational 4-bit ALU slice, time-shared between the low and high passes.
module sm83_alu_nibble
  import sm83_alu_pkg::*;
#(
  parameter int unsigned W = 4
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  input  logic         cin,
  input  nib_mode_t    mode,
  output logic [W-1:0] sum,
  output logic         cout,
  output logic         nib_zero
);

  localparam int unsigned WF = W + 1;

  logic [W:0] add_full;

  always_comb begin
    add_full = {1'b0, x} + {1'b0, y} + WF'(cin);
    sum      = add_full[W-1:0];
    cout     = 1'b0;
    unique case (mode)
      NM_ADD: cout = add_full[W];
      NM_AND: sum  = x & y;
      NM_OR:  sum  = x | y;
      NM_XOR: sum  = x ^ y;
    endcase
    nib_zero = (sum == '0);
  end

endmodule

// File: rtl/sm83_alu_nibble_seq.sv
// Two-pass (low nibble, high nibble) 8-bit SM83 ALU with registered result and flag strobes.
module sm83_alu_nibble_seq
  import sm83_alu_pkg::*;
#(
  parameter int unsigned WORD_SIZE = 8,
  parameter int unsigned NIBBLE    = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic [3:0]           op,
  input  logic [WORD_SIZE-1:0] a,
  input  logic [WORD_SIZE-1:0] b,
  input  logic                 carry_flag,
  input  logic                 half_flag,
  input  logic                 neg_flag,
  output logic                 busy,
  output logic                 done,
  output logic [WORD_SIZE-1:0] result,
  output logic                 result_we,
  output logic                 zero_out,
  output logic                 half_out,
  output logic                 neg_out,
  output logic                 carry_out,
  output logic                 daa_carry_out
);

  alu_state_t           state_q, state_d;
  logic                 busy_q, busy_d, done_q, done_d, pend_q, pend_d;
  logic [WORD_SIZE-1:0] x_q, x_d, y_q, y_d;
  logic                 cin_q, cin_d, inv_q, inv_d, we_q, we_d, neg_q, neg_d;
  logic                 daa_c_q, daa_c_d;
  nib_mode_t            mode_q, mode_d;
  flag_kind_t           kind_q, kind_d;
  logic [NIBBLE-1:0]    lo_q, lo_d;
  logic                 nc_q, nc_d, lz_q, lz_d;
  logic [WORD_SIZE-1:0] fin_res_q, fin_res_d;
  logic                 fin_z_q, fin_z_d, fin_h_q, fin_h_d, fin_c_q, fin_c_d;
  logic [WORD_SIZE-1:0] result_q, result_d;
  logic                 result_we_q, result_we_d, zero_q, zero_d, half_q, half_d;
  logic                 neg_out_q, neg_out_d, carry_q, carry_d, daa_out_q, daa_out_d;

  logic [NIBBLE-1:0]    sl_x, sl_y, sl_sum;
  logic                 sl_cin, sl_cout, sl_zero;
  logic [WORD_SIZE-1:0] daa_corr;
  logic                 daa_c;

  sm83_alu_nibble #(.W(NIBBLE)) u_slice (
    .x        (sl_x),
    .y        (sl_y),
    .cin      (sl_cin),
    .mode     (mode_q),
    .sum      (sl_sum),
    .cout     (sl_cout),
    .nib_zero (sl_zero)
  );

  // Slice operand mux: low nibble in LO, high nibble plus chained carry in HI.
  always_comb begin
    sl_x   = x_q[NIBBLE-1:0];
    sl_y   = y_q[NIBBLE-1:0];
    sl_cin = cin_q;
    if (state_q == ST_HI) begin
      sl_x   = x_q[WORD_SIZE-1:NIBBLE];
      sl_y   = y_q[WORD_SIZE-1:NIBBLE];
      sl_cin = nc_q;
    end
  end

  // DAA correction byte, decided from the live inputs at accept.
  always_comb begin
    daa_corr = '0;
    daa_c    = 1'b0;
    if (!neg_flag) begin
      if (half_flag || (a[3:0] > DAA_LO_LIMIT)) daa_corr = daa_corr | DAA_LO_ADJ;
      if (carry_flag || (a > DAA_HI_LIMIT)) begin
        daa_corr = daa_corr | DAA_HI_ADJ;
        daa_c    = 1'b1;
      end
    end else begin
      if (half_flag)  daa_corr = daa_corr | DAA_LO_ADJ;
      if (carry_flag) daa_corr = daa_corr | DAA_HI_ADJ;
      daa_c = carry_flag;
    end
  end

  always_comb begin
    state_d     = state_q;
    busy_d      = (state_q != ST_IDLE);
    done_d      = pend_q;
    pend_d      = 1'b0;
    x_d         = x_q;
    y_d         = y_q;
    cin_d       = cin_q;
    inv_d       = inv_q;
    we_d        = we_q;
    neg_d       = neg_q;
    daa_c_d     = daa_c_q;
    mode_d      = mode_q;
    kind_d      = kind_q;
    lo_d        = lo_q;
    nc_d        = nc_q;
    lz_d        = lz_q;
    fin_res_d   = fin_res_q;
    fin_z_d     = fin_z_q;
    fin_h_d     = fin_h_q;
    fin_c_d     = fin_c_q;
    result_d    = result_q;
    result_we_d = result_we_q;
    zero_d      = zero_q;
    half_d      = half_q;
    neg_out_d   = neg_out_q;
    carry_d     = carry_q;
    daa_out_d   = daa_out_q;

    unique case (state_q)
      ST_IDLE: begin
        // busy_q still covers the cycle before done, so start is ignored there.
        if (start && !busy_q) begin
          state_d = ST_LO;
          x_d     = a;
          y_d     = b;
          cin_d   = 1'b0;
          inv_d   = 1'b0;
          we_d    = 1'b1;
          neg_d   = 1'b0;
          daa_c_d = 1'b0;
          mode_d  = NM_ADD;
          kind_d  = FK_ARITH;
          case (op)
            OP_ADD: ;
            OP_ADC: cin_d = carry_flag;
            OP_SUB, OP_CP: begin
              y_d   = ~b;
              cin_d = 1'b1;
              inv_d = 1'b1;
              neg_d = 1'b1;
              we_d  = (op != OP_CP);
            end
            OP_SBC: begin
              y_d   = ~b;
              cin_d = !carry_flag;
              inv_d = 1'b1;
              neg_d = 1'b1;
            end
            OP_AND: begin
              mode_d = NM_AND;
              kind_d = FK_AND;
            end
            OP_XOR: begin
              mode_d = NM_XOR;
              kind_d = FK_LOGIC;
            end
            OP_OR: begin
              mode_d = NM_OR;
              kind_d = FK_LOGIC;
            end
            OP_DAA: begin
              kind_d  = FK_DAA;
              neg_d   = neg_flag;
              daa_c_d = daa_c;
              y_d     = neg_flag ? ~daa_corr : daa_corr;
              cin_d   = neg_flag;
            end
            default: we_d = 1'b0;
          endcase
        end
      end
      ST_LO: begin
        state_d = ST_HI;
        lo_d    = sl_sum;
        nc_d    = sl_cout;
        lz_d    = sl_zero;
      end
      ST_HI: begin
        state_d   = ST_IDLE;
        pend_d    = 1'b1;
        fin_res_d = {sl_sum, lo_q};
        fin_z_d   = lz_q & sl_zero;
        unique case (kind_q)
          FK_ARITH: begin
            fin_h_d = nc_q ^ inv_q;
            fin_c_d = sl_cout ^ inv_q;
          end
          FK_AND: begin
            fin_h_d = 1'b1;
            fin_c_d = 1'b0;
          end
          FK_LOGIC: begin
            fin_h_d = 1'b0;
            fin_c_d = 1'b0;
          end
          FK_DAA: begin
            fin_h_d = 1'b0;
            fin_c_d = daa_c_q;
          end
        endcase
      end
      default: state_d = ST_IDLE;
    endcase

    // Publish together with done so outputs hold between operations.
    if (pend_q) begin
      result_d    = fin_res_q;
      result_we_d = we_q;
      zero_d      = fin_z_q;
      half_d      = fin_h_q;
      neg_out_d   = neg_q;
      carry_d     = fin_c_q;
      daa_out_d   = daa_c_q;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pend_q      <= 1'b0;
      x_q         <= '0;
      y_q         <= '0;
      cin_q       <= 1'b0;
      inv_q       <= 1'b0;
      we_q        <= 1'b0;
      neg_q       <= 1'b0;
      daa_c_q     <= 1'b0;
      mode_q      <= NM_ADD;
      kind_q      <= FK_ARITH;
      lo_q        <= '0;
      nc_q        <= 1'b0;
      lz_q        <= 1'b0;
      fin_res_q   <= '0;
      fin_z_q     <= 1'b0;
      fin_h_q     <= 1'b0;
      fin_c_q     <= 1'b0;
      result_q    <= '0;
      result_we_q <= 1'b0;
      zero_q      <= 1'b0;
      half_q      <= 1'b0;
      neg_out_q   <= 1'b0;
      carry_q     <= 1'b0;
      daa_out_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pend_q      <= pend_d;
      x_q         <= x_d;
      y_q         <= y_d;
      cin_q       <= cin_d;
      inv_q       <= inv_d;
      we_q        <= we_d;
      neg_q       <= neg_d;
      daa_c_q     <= daa_c_d;
      mode_q      <= mode_d;
      kind_q      <= kind_d;
      lo_q        <= lo_d;
      nc_q        <= nc_d;
      lz_q        <= lz_d;
      fin_res_q   <= fin_res_d;
      fin_z_q     <= fin_z_d;
      fin_h_q     <= fin_h_d;
      fin_c_q     <= fin_c_d;
      result_q    <= result_d;
      result_we_q <= result_we_d;
      zero_q      <= zero_d;
      half_q      <= half_d;
      neg_out_q   <= neg_out_d;
      carry_q     <= carry_d;
      daa_out_q   <= daa_out_d;
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign result        = result_q;
  assign result_we     = result_we_q;
  assign zero_out      = zero_q;
  assign half_out      = half_q;
  assign neg_out       = neg_out_q;
  assign carry_out     = carry_q;
  assign daa_carry_out = daa_out_q;

endmodule

// File: tb/tb_sm83_alu_nibble_seq.sv
// Directed self-checking bench for sm83_alu_nibble_seq.
module tb_sm83_alu_nibble_seq;

  localparam logic [3:0] T_ADD = 4'd0;
  localparam logic [3:0] T_ADC = 4'd1;
  localparam logic [3:0] T_SUB = 4'd2;
  localparam logic [3:0] T_SBC = 4'd3;
  localparam logic [3:0] T_AND = 4'd4;
  localparam logic [3:0] T_XOR = 4'd5;
  localparam logic [3:0] T_OR  = 4'd6;
  localparam logic [3:0] T_CP  = 4'd7;
  localparam logic [3:0] T_DAA = 4'd8;

  logic       clk, reset_n, start;
  logic [3:0] op;
  logic [7:0] a, b;
  logic       carry_flag, half_flag, neg_flag;
  logic       busy, done, result_we, zero_out, half_out, neg_out, carry_out, daa_carry_out;
  logic [7:0] result;

  int n_assert = 0;
  int n_fail   = 0;

  sm83_alu_nibble_seq dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .start         (start),
    .op            (op),
    .a             (a),
    .b             (b),
    .carry_flag    (carry_flag),
    .half_flag     (half_flag),
    .neg_flag      (neg_flag),
    .busy          (busy),
    .done          (done),
    .result        (result),
    .result_we     (result_we),
    .zero_out      (zero_out),
    .half_out      (half_out),
    .neg_out       (neg_out),
    .carry_out     (carry_out),
    .daa_carry_out (daa_carry_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic [7:0] r, input logic we,
                            input logic z, input logic h, input logic n, input logic c,
                            input logic d);
    chk({tag, ".result"},    32'(result),        32'(r));
    chk({tag, ".result_we"}, 32'(result_we),     32'(we));
    chk({tag, ".zero"},      32'(zero_out),      32'(z));
    chk({tag, ".half"},      32'(half_out),      32'(h));
    chk({tag, ".neg"},       32'(neg_out),       32'(n));
    chk({tag, ".carry"},     32'(carry_out),     32'(c));
    chk({tag, ".daa_carry"}, 32'(daa_carry_out), 32'(d));
  endtask

  // Issue one op, scramble inputs after accept, and wait (bounded) for done.
  task automatic do_op(input string tag, input logic [3:0] o, input logic [7:0] aa,
                       input logic [7:0] bb, input logic cf, input logic hf, input logic nf);
    int   lat;
    logic busy1, busy_done;
    op = o; a = aa; b = bb; carry_flag = cf; half_flag = hf; neg_flag = nf;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a = ~aa; b = ~bb; carry_flag = ~cf; half_flag = ~hf; neg_flag = ~nf; op = T_XOR;
    lat = 0; busy1 = 1'b0; busy_done = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      @(posedge clk); #1;
      if (i == 1) busy1 = busy;
      if (done) begin
        lat       = i;
        busy_done = busy;
        break;
      end
    end
    chk({tag, ".latency"},   32'(lat),       32'd3);
    chk({tag, ".busy_mid"},  32'(busy1),     32'd1);
    chk({tag, ".busy_done"}, 32'(busy_done), 32'd0);
  endtask

  task automatic hold_check(input string tag, input logic [7:0] r);
    @(posedge clk); #1;
    chk({tag, ".done_clear"}, 32'(done),   32'd0);
    chk({tag, ".hold"},       32'(result), 32'(r));
  endtask

  logic [7:0] va [6];
  logic [7:0] vb [6];
  int         ndone, e1, e2;
  logic [7:0] r1, r2;

  initial begin
    reset_n = 1'b0; start = 1'b0; op = 4'd0; a = 8'h00; b = 8'h00;
    carry_flag = 1'b0; half_flag = 1'b0; neg_flag = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.busy", 32'(busy), 32'd0);
    chk("rst.done", 32'(done), 32'd0);
    check_outs("rst", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    reset_n = 1'b1;
    @(posedge clk); #1;

    do_op("add", T_ADD, 8'h3A, 8'hC6, 1'b0, 1'b0, 1'b0);
    check_outs("add", 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    hold_check("add", 8'h00);

    do_op("sbc", T_SBC, 8'h3B, 8'h4F, 1'b1, 1'b0, 1'b0);
    check_outs("sbc", 8'hEB, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    hold_check("sbc", 8'hEB);

    do_op("cp", T_CP, 8'h3E, 8'h3E, 1'b0, 1'b0, 1'b0);
    check_outs("cp", 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    hold_check("cp", 8'h00);

    do_op("and", T_AND, 8'hF0, 8'h0F, 1'b1, 1'b0, 1'b0);
    check_outs("and", 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    hold_check("and", 8'h00);

    do_op("daa7d", T_DAA, 8'h7D, 8'hFF, 1'b0, 1'b0, 1'b0);
    check_outs("daa7d", 8'h83, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    hold_check("daa7d", 8'h83);

    do_op("daa9a", T_DAA, 8'h9A, 8'h00, 1'b0, 1'b0, 1'b0);
    check_outs("daa9a", 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    hold_check("daa9a", 8'h00);

    do_op("daasub", T_DAA, 8'h0F, 8'h00, 1'b0, 1'b1, 1'b1);
    check_outs("daasub", 8'h09, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    hold_check("daasub", 8'h09);

    do_op("adc", T_ADC, 8'h0F, 8'h00, 1'b1, 1'b0, 1'b0);
    check_outs("adc", 8'h10, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    hold_check("adc", 8'h10);

    do_op("sub", T_SUB, 8'h10, 8'h01, 1'b1, 1'b0, 1'b0);
    check_outs("sub", 8'h0F, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    hold_check("sub", 8'h0F);

    do_op("xor", T_XOR, 8'h5A, 8'h5A, 1'b1, 1'b1, 1'b0);
    check_outs("xor", 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    hold_check("xor", 8'h00);

    do_op("or", T_OR, 8'h50, 8'h05, 1'b0, 1'b0, 1'b0);
    check_outs("or", 8'h55, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    hold_check("or", 8'h55);

    do_op("unk", 4'hF, 8'h12, 8'h34, 1'b1, 1'b0, 1'b0);
    check_outs("unk", 8'h46, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    hold_check("unk", 8'h46);

    // start held for six edges with operands changing every cycle
    va = '{8'h01, 8'h11, 8'h21, 8'h31, 8'h41, 8'h51};
    vb = '{8'h02, 8'h22, 8'h32, 8'h42, 8'h52, 8'h62};
    op = T_ADD; carry_flag = 1'b0; half_flag = 1'b0; neg_flag = 1'b0;
    a = va[0]; b = vb[0]; start = 1'b1;
    ndone = 0; e1 = -1; e2 = -1; r1 = 8'h00; r2 = 8'h00;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (i < 5) begin
        a = va[i+1];
        b = vb[i+1];
      end
      if (i == 5) start = 1'b0;
      if (done) begin
        ndone++;
        if (ndone == 1) begin
          r1 = result; e1 = i;
        end else begin
          r2 = result; e2 = i;
        end
      end
    end
    chk("b2b.count",   32'(ndone), 32'd2);
    chk("b2b.edge1",   32'(e1),    32'd3);
    chk("b2b.edge2",   32'(e2),    32'd7);
    chk("b2b.result1", 32'(r1),    32'h03);
    chk("b2b.result2", 32'(r2),    32'h93);

    // reset asserted while the high pass is in flight
    op = T_ADD; a = 8'h0F; b = 8'h01; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b0;
    #1;
    chk("arst.busy", 32'(busy), 32'd0);
    chk("arst.done", 32'(done), 32'd0);
    check_outs("arst", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    ndone = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
    reset_n = 1'b1;
    repeat (4) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
    chk("arst.no_done", 32'(ndone), 32'd0);

    do_op("post", T_ADD, 8'h0F, 8'h01, 1'b0, 1'b0, 1'b0);
    check_outs("post", 8'h10, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    hold_check("post", 8'h10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
